ula_seq_ctrl: RTL and testbench

//   Registered front-end/back-end for the 8-bit combinational ULA. Accepts one op (opcode, A, B) via valid/ready.

---
 rtl/ula_pkg.sv | 33 +++
 rtl/ula_seq_ctrl.sv | 131 +++++++++++++
 tb/tb_ula_seq_ctrl.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ula_pkg.sv
// Shared definitions for the ULA sequencer: op encodings, one-hot ULA
// control words, FSM state type and the op -> control decode.
package ula_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_OR  = 2'b11;

    localparam logic [3:0] CTRL_ADD = 4'b0001;
    localparam logic [3:0] CTRL_SUB = 4'b0010;
    localparam logic [3:0] CTRL_AND = 4'b0100;
    localparam logic [3:0] CTRL_OR  = 4'b1000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Map the 2-bit op code onto the ULA's one-hot control word.
    function automatic logic [3:0] op_to_ctrl(input logic [1:0] op);
        logic [3:0] ctrl;
        unique case (op)
            OP_ADD:  ctrl = CTRL_ADD;
            OP_SUB:  ctrl = CTRL_SUB;
            OP_AND:  ctrl = CTRL_AND;
            default: ctrl = CTRL_OR;
        endcase
        return ctrl;
    endfunction

endpackage

// File: rtl/ula_seq_ctrl.sv
// Registered front/back end around the combinational 8-bit ULA.
// Accepts one op via valid/ready, drives the ULA from registers, captures
// the result one cycle later and offers it downstream via valid/ready.
// Optional build macro ULA_FLAGS_EN adds registered out_zero/out_neg flags.
module ula_seq_ctrl
    import ula_pkg::*;
#(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned COUNT_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [1:0]         in_op,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    output logic [3:0]         alu_ctrl,
    output logic [WIDTH-1:0]   alu_a,
    output logic [WIDTH-1:0]   alu_b,
    input  logic [WIDTH-1:0]   alu_result,
    input  logic               alu_carry,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_result,
    output logic               out_carry,
    output logic [COUNT_W-1:0] op_count
`ifdef ULA_FLAGS_EN
    ,
    output logic               out_zero,
    output logic               out_neg
`endif
);

    state_t             state_q,      state_d;
    logic [3:0]         alu_ctrl_q,   alu_ctrl_d;
    logic [WIDTH-1:0]   alu_a_q,      alu_a_d;
    logic [WIDTH-1:0]   alu_b_q,      alu_b_d;
    logic [WIDTH-1:0]   out_result_q, out_result_d;
    logic               out_carry_q,  out_carry_d;
    logic [COUNT_W-1:0] op_count_q,   op_count_d;
`ifdef ULA_FLAGS_EN
    logic               out_zero_q,   out_zero_d;
    logic               out_neg_q,    out_neg_d;
`endif

    // Next-state and datapath register updates for the IDLE -> EXEC -> DONE cycle.
    always_comb begin
        state_d      = state_q;
        alu_ctrl_d   = alu_ctrl_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        out_result_d = out_result_q;
        out_carry_d  = out_carry_q;
        op_count_d   = op_count_q;
`ifdef ULA_FLAGS_EN
        out_zero_d   = out_zero_q;
        out_neg_d    = out_neg_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    alu_a_d    = in_a;
                    alu_b_d    = in_b;
                    alu_ctrl_d = op_to_ctrl(in_op);
                    state_d    = ST_EXEC;
                end
            end
            ST_EXEC: begin
                out_result_d = alu_result;
                // The ULA always reports the A+B carry; only ADD exposes it.
                out_carry_d  = (alu_ctrl_q == CTRL_ADD) ? alu_carry : 1'b0;
`ifdef ULA_FLAGS_EN
                out_zero_d   = (alu_result == '0);
                out_neg_d    = alu_result[WIDTH-1];
`endif
                state_d      = ST_DONE;
            end
            ST_DONE: begin
                if (out_ready) begin
                    op_count_d = op_count_q + COUNT_W'(1);
                    state_d    = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers; async reset discards any in-flight op.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            alu_ctrl_q   <= CTRL_ADD;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            out_result_q <= '0;
            out_carry_q  <= 1'b0;
            op_count_q   <= '0;
`ifdef ULA_FLAGS_EN
            out_zero_q   <= 1'b0;
            out_neg_q    <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            alu_ctrl_q   <= alu_ctrl_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            out_result_q <= out_result_d;
            out_carry_q  <= out_carry_d;
            op_count_q   <= op_count_d;
`ifdef ULA_FLAGS_EN
            out_zero_q   <= out_zero_d;
            out_neg_q    <= out_neg_d;
`endif
        end
    end

    assign in_ready   = (state_q == ST_IDLE);
    assign out_valid  = (state_q == ST_DONE);
    assign alu_ctrl   = alu_ctrl_q;
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign out_result = out_result_q;
    assign out_carry  = out_carry_q;
    assign op_count   = op_count_q;
`ifdef ULA_FLAGS_EN
    assign out_zero   = out_zero_q;
    assign out_neg    = out_neg_q;
`endif

endmodule

// File: tb/tb_ula_seq_ctrl.sv
// Scoreboard bench for ula_seq_ctrl with a behavioural ULA in the loop.
// Honours ULA_FLAGS_EN for the optional flag outputs.
module tb_ula_seq_ctrl;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_op;
    logic [7:0]  in_a;
    logic [7:0]  in_b;
    logic [3:0]  alu_ctrl;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic [7:0]  alu_result;
    logic        alu_carry;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_result;
    logic        out_carry;
    logic [15:0] op_count;
`ifdef ULA_FLAGS_EN
    logic        out_zero;
    logic        out_neg;
`endif

    ula_seq_ctrl #(.WIDTH(8), .COUNT_W(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_a       (in_a),
        .in_b       (in_b),
        .alu_ctrl   (alu_ctrl),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_result (alu_result),
        .alu_carry  (alu_carry),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_carry  (out_carry),
        .op_count   (op_count)
`ifdef ULA_FLAGS_EN
        ,
        .out_zero   (out_zero),
        .out_neg    (out_neg)
`endif
    );

    // Behavioural ULA: carry is always that of A+B, whatever the op.
    logic [8:0] ula_sum;
    always_comb begin
        ula_sum   = {1'b0, alu_a} + {1'b0, alu_b};
        alu_carry = ula_sum[8];
        case (alu_ctrl)
            4'b0001: alu_result = ula_sum[7:0];
            4'b0010: alu_result = alu_a - alu_b;
            4'b0100: alu_result = alu_a & alu_b;
            4'b1000: alu_result = alu_a | alu_b;
            default: alu_result = 8'h00;
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [3:0] ctrl;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] res;
        logic       carry;
        logic       zero;
        logic       neg;
        int         acc_cyc;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] exp_count = 16'd0;
    int          n_tests = 0;
    int          n_fail  = 0;
    bit          stream_chk = 1'b0;
    bit          have_prev_acc = 1'b0;
    int          prev_acc = 0;
    bit          prev_ov = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic exp_t ref_op(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        exp_t e;
        logic [8:0] s;
        s = {1'b0, a} + {1'b0, b};
        e.a = a;
        e.b = b;
        e.carry = 1'b0;
        case (op)
            2'b00: begin e.ctrl = 4'b0001; e.res = s[7:0]; e.carry = s[8]; end
            2'b01: begin e.ctrl = 4'b0010; e.res = a - b; end
            2'b10: begin e.ctrl = 4'b0100; e.res = a & b; end
            default: begin e.ctrl = 4'b1000; e.res = a | b; end
        endcase
        e.zero = (e.res == 8'h00);
        e.neg  = e.res[7];
        e.acc_cyc = 0;
        return e;
    endfunction

    // Monitor: sample mid-cycle; push on accept, check EXEC controls, check/pop on output.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (in_valid && in_ready) begin
                e = ref_op(in_op, in_a, in_b);
                e.acc_cyc = cyc;
                if (stream_chk && have_prev_acc)
                    check("throughput", 32'(cyc - prev_acc), 32'd3);
                prev_acc = cyc;
                have_prev_acc = 1'b1;
                sb.push_back(e);
            end else if (!in_ready) begin
                if (sb.size() == 0) begin
                    check("sb_empty", 32'(sb.size()), 32'd1);
                end else if (!out_valid) begin
                    check("exec_ctrl", 32'(alu_ctrl), 32'(sb[0].ctrl));
                    check("exec_a", 32'(alu_a), 32'(sb[0].a));
                    check("exec_b", 32'(alu_b), 32'(sb[0].b));
                end else begin
                    if (!prev_ov)
                        check("latency", 32'(cyc - sb[0].acc_cyc), 32'd2);
                    check("result", 32'(out_result), 32'(sb[0].res));
                    check("carry", 32'(out_carry), 32'(sb[0].carry));
`ifdef ULA_FLAGS_EN
                    check("zero", 32'(out_zero), 32'(sb[0].zero));
                    check("neg", 32'(out_neg), 32'(sb[0].neg));
`endif
                    check("count_hold", 32'(op_count), 32'(exp_count));
                    if (out_ready) begin
                        void'(sb.pop_front());
                        exp_count = exp_count + 16'd1;
                    end
                end
            end
            prev_ov = out_valid;
        end else begin
            prev_ov = 1'b0;
        end
    end

    // Present an op and hold it until accepted; in_valid is left high.
    task automatic send(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        bit ok;
        ok = 1'b0;
        in_op = op;
        in_a = a;
        in_b = b;
        in_valid = 1'b1;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (in_ready) ok = 1'b1;
        end
        check("send_accept", 32'(ok), 32'd1);
        @(posedge clk);
        #2;
    endtask

    task automatic do_op(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        send(op, a, b);
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 60 && !ok; i++) begin
            if (in_ready && sb.size() == 0) ok = 1'b1;
            else begin
                @(posedge clk);
                #2;
            end
        end
        check("drain", 32'(ok), 32'd1);
    endtask

    initial begin
        rst_n = 1'b1;
        in_valid = 1'b0;
        in_op = 2'b00;
        in_a = 8'h00;
        in_b = 8'h00;
        out_ready = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_ctrl", 32'(alu_ctrl), 32'h1);
        check("rst_alu_a", 32'(alu_a), 32'd0);
        check("rst_alu_b", 32'(alu_b), 32'd0);
        check("rst_result", 32'(out_result), 32'd0);
        check("rst_carry", 32'(out_carry), 32'd0);
        check("rst_count", 32'(op_count), 32'd0);
`ifdef ULA_FLAGS_EN
        check("rst_zero", 32'(out_zero), 32'd0);
        check("rst_neg", 32'(out_neg), 32'd0);
`endif
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #2;

        // ADD with carry out
        do_op(2'b00, 8'hF0, 8'h20);
        wait_idle();
        check("add_count", 32'(op_count), 32'd1);

        // SUB / AND / OR; ULA carry is set on some of these and must be masked
        do_op(2'b01, 8'h05, 8'h07);
        do_op(2'b01, 8'hF0, 8'h20);
        do_op(2'b10, 8'hCC, 8'hAA);
        do_op(2'b11, 8'hCC, 8'hAA);
        wait_idle();
        check("logic_count", 32'(op_count), 32'd5);

        // Backpressure: result held, new in_valid ignored
        out_ready = 1'b0;
        send(2'b00, 8'h01, 8'h01);
        in_op = 2'b11;
        in_a = 8'h55;
        in_b = 8'h0F;
        repeat (7) @(posedge clk);
        #2;
        check("bp_valid", 32'(out_valid), 32'd1);
        check("bp_in_ready", 32'(in_ready), 32'd0);
        check("bp_result", 32'(out_result), 32'h02);
        check("bp_count", 32'(op_count), 32'd5);
        in_valid = 1'b0;
        out_ready = 1'b1;
        wait_idle();
        check("bp_count_rel", 32'(op_count), 32'd6);

        // Async reset mid-DONE discards the result
        out_ready = 1'b0;
        do_op(2'b00, 8'h33, 8'h44);
        repeat (2) @(posedge clk);
        #2;
        check("pre_rst_valid", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_ready", 32'(in_ready), 32'd1);
        check("mid_rst_count", 32'(op_count), 32'd0);
        check("mid_rst_result", 32'(out_result), 32'd0);
        sb.delete();
        exp_count = 16'd0;
        out_ready = 1'b1;
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #2;

        // Back-to-back stream of 10 ops
        stream_chk = 1'b1;
        have_prev_acc = 1'b0;
        for (int i = 0; i < 10; i++)
            send(2'($urandom_range(3)), 8'($urandom), 8'($urandom));
        in_valid = 1'b0;
        wait_idle();
        stream_chk = 1'b0;
        check("stream_count", 32'(op_count), 32'd10);

        // Counter wrap from a preloaded value
        force dut.op_count_q = 16'hFFFE;
        @(posedge clk);
        #2;
        release dut.op_count_q;
        exp_count = 16'hFFFE;
        do_op(2'b10, 8'h12, 8'h34);
        wait_idle();
        check("count_ffff", 32'(op_count), 32'hFFFF);
        do_op(2'b11, 8'h12, 8'h34);
        wait_idle();
        check("count_wrap", 32'(op_count), 32'd0);

`ifdef ULA_FLAGS_EN
        do_op(2'b10, 8'h0F, 8'hF0);
        wait_idle();
        check("flag_zero_z", 32'(out_zero), 32'd1);
        check("flag_zero_n", 32'(out_neg), 32'd0);
        do_op(2'b01, 8'h00, 8'h01);
        wait_idle();
        check("flag_neg_z", 32'(out_zero), 32'd0);
        check("flag_neg_n", 32'(out_neg), 32'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Hard stop so the bench can never hang.
    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
